iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider. Acts as the responder side of the EX-stage start/ready divide handshake.
- EX asserts start_i and holds the operands stable while stalling. The divider computes for 32 iterations, then presents the 64-bit {remainder, quotient} together with a one-state ready_o.
- EX writes remainder to HI and quotient to LO.

---
 rtl/iter_divider.sv | 145 ++++++++++++++
 tb/tb_iter_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// ============================================================================
//  Module      : iter_divider
//  Description : Multi-cycle radix-2 restoring divider (start/ready responder)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   typedef enum logic [1:0] {
      S_FREE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_BUSY    = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_dvs;
   logic [DATA_W-1:0] r_rem;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_signed;
   logic              r_neg_q;
   logic              r_neg_r;

   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_sub;
   logic              w_ge;
   logic [DATA_W-1:0] w_rem_next;
   logic [DATA_W-1:0] w_dvd_next;
   logic [DATA_W-1:0] w_q_fix;
   logic [DATA_W-1:0] w_r_fix;
   logic [DATA_W-1:0] w_abs_a;
   logic [DATA_W-1:0] w_abs_b;
   logic              w_last;

   // The dividend register doubles as the quotient shift register.
   assign w_shift    = {r_rem, r_dvd[DATA_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_dvs});
   assign w_sub      = w_shift[DATA_W-1:0] - r_dvs;
   assign w_rem_next = w_ge ? w_sub : w_shift[DATA_W-1:0];
   assign w_dvd_next = {r_dvd[DATA_W-2:0], w_ge};
   assign w_last     = (r_cnt == CNT_W'(DATA_W-1));

   assign w_q_fix = (r_signed && r_neg_q) ? (~w_dvd_next + 1'b1) : w_dvd_next;
   assign w_r_fix = (r_signed && r_neg_r) ? (~w_rem_next + 1'b1) : w_rem_next;

   assign w_abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
   assign w_abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FREE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FREE: begin
            if (start_i && !annul_i)
               w_next = (opdata2_i == '0) ? S_DIVZERO : S_BUSY;
         end
         S_DIVZERO: w_next = S_END;
         S_BUSY: begin
            if (annul_i)     w_next = S_FREE;
            else if (w_last) w_next = S_END;
         end
         S_END: begin
            if (!start_i) w_next = S_FREE;
         end
         default: w_next = S_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (r_state)
            S_FREE: begin
               if (w_next == S_BUSY) begin
                  r_dvd    <= w_abs_a;
                  r_dvs    <= w_abs_b;
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_signed <= signed_div_i;
                  r_neg_q  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  r_neg_r  <= signed_div_i & opdata1_i[DATA_W-1];
               end
            end
            S_DIVZERO: begin
               result_o <= '0;
               ready_o  <= 1'b1;
            end
            S_BUSY: begin
               if (!annul_i) begin
                  r_rem <= w_rem_next;
                  r_dvd <= w_dvd_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     result_o <= {w_r_fix, w_q_fix};
                     ready_o  <= 1'b1;
                  end
               end
            end
            S_END: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
            default: begin
               result_o <= '0;
               ready_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
//  Module      : tb_iter_divider
//  Description : Self-checking bench for iter_divider with a longint reference
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;

   iter_divider #(.DATA_W(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
      return (b == 32'd0) ? 2 : 33;
   endfunction

   // Issues one divide and waits for ready; optionally drops start and checks the release.
   task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle, input bit drop,
                          output logic [63:0] res, output int lat);
      signed_div = s; op1 = a; op2 = b; start = 1'b1; lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (toggle) begin
            op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
         end
      end while (!ready && lat < 100);
      res = result;
      n_checks++;
      if (!ready) begin
         n_fail++;
         $display("FAIL timeout: ready=%0b after %0d cycles, required 1", ready, lat);
      end
      if (drop) begin
         start = 1'b0;
         @(posedge clk); #1;
         n_checks++;
         if (ready !== 1'b0 || result !== 64'd0) begin
            n_fail++;
            $display("FAIL release: ready=%0b result=%h, required 0 and 0", ready, result);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %0b, required 0", ready);
      end
      n_checks++;
      if (result !== 64'd0) begin
         n_fail++; $display("FAIL reset_result: got %h, required 0", result);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [63:0] res;
      int lat;
      bit          s_t [6] = '{0, 1, 1, 0, 1, 0};
      logic [31:0] a_t [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd5};
      logic [31:0] b_t [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'd0};
      logic [63:0] e_t [6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                               64'h00000001_FFFFFFFD, 64'h00000001_7FFFFFFC,
                               64'h00000000_80000000, 64'h0};
      for (int i = 0; i < 6; i++) begin
         run_div(s_t[i], a_t[i], b_t[i], 1'b0, 1'b1, res, lat);
         n_checks++;
         if (res !== e_t[i] || res !== model(s_t[i], a_t[i], b_t[i])) begin
            n_fail++;
            $display("FAIL directed_%0d result: got %h, required %h", i, res, e_t[i]);
         end
         n_checks++;
         if (lat != exp_lat(b_t[i])) begin
            n_fail++;
            $display("FAIL directed_%0d latency: got %0d, required %0d", i, lat, exp_lat(b_t[i]));
         end
      end
      run_div(1'b1, 32'hFFFFFFF3, 32'd0, 1'b0, 1'b1, res, lat);
      n_checks++;
      if (res !== 64'd0 || lat != 2) begin
         n_fail++;
         $display("FAIL signed_divzero: got %h lat %0d, required 0 lat 2", res, lat);
      end
   endtask

   task automatic test_annul();
      logic [63:0] res;
      int lat;
      bit seen = 0;
      signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1;
      end
      annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      annul = 1'b0;
      if (ready) seen = 1;
      n_checks++;
      if (seen || result !== 64'd0) begin
         n_fail++;
         $display("FAIL annul_quiet: ready seen=%0b result=%h, required 0 and 0", seen, result);
      end
      run_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b1, res, lat);
      n_checks++;
      if (res !== 64'h00000000_00000003 || lat != 33) begin
         n_fail++;
         $display("FAIL annul_next: got %h lat %0d, required 0000000000000003 lat 33", res, lat);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0 || result !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_mid: ready=%0b result=%h, required 0 and 0", ready, result);
      end
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready || result !== 64'd0) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_fail++; $display("FAIL reset_mid_quiet: activity=%0b, required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r1, r2;
      int l1, l2;
      run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b1, r1, l1);
      run_div(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b1, r2, l2);
      n_checks++;
      if (r1 !== 64'h00000002_0000000E) begin
         n_fail++; $display("FAIL b2b_first: got %h, required 000000020000000e", r1);
      end
      n_checks++;
      if (r2 !== 64'h0000000F_0FFFFFFF || l2 != 33) begin
         n_fail++;
         $display("FAIL b2b_second: got %h lat %0d, required 0000000f0fffffff lat 33", r2, l2);
      end
   endtask

   task automatic test_hold_start();
      logic [63:0] res;
      int lat;
      bit bad = 0;
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, res, lat);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b1 || result !== model(1'b1, 32'hFFFFFF9C, 32'd7)) bad = 1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL hold_start: ready=%0b result=%h, required 1 and %h",
                  ready, result, model(1'b1, 32'hFFFFFF9C, 32'd7));
      end
      start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: ready=%0b, required 0", ready);
      end
   endtask

   task automatic test_random();
      logic [63:0] res;
      int lat;
      bit s;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 255));
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_div(s, a, b, 1'b1, 1'b1, res, lat);
         n_checks++;
         if (res !== model(s, a, b) || lat != exp_lat(b)) begin
            n_fail++;
            $display("FAIL random_%0d s=%0b %h/%h: got %h lat %0d, required %h lat %0d",
                     i, s, a, b, res, lat, model(s, a, b), exp_lat(b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      test_hold_start();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
